spi_seq: RTL and testbench
==========================

SPI_SEQ -- requirements
Module: spi_seq

Interface
REQ-001 SHALL have parameter CS_SETUP, default 2, the number of cycles CS_N is low before the first W_STB (range 1..15).
REQ-002 SHALL have parameter CS_HOLD, default 2, the number of cycles CS_N stays low after the last byte completes (range 1..15).
REQ-003 SHALL have parameter TIMEOUT, default 32, the per-byte cycle limit from the W_STB cycle to completion of that byte (range 12..63).
REQ-004 SHALL have port IN_SCLK, input, 1 bit: the single clock, shared with the byte engine; all logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port REQ, input, 2 bits: per-requester transaction request, level-sensitive.
REQ-007 SHALL have ports LEN0 and LEN1, input, 4 bits each: byte count for requester 0 and 1; 0 means no transaction.
REQ-008 SHALL have ports TX_DATA0 and TX_DATA1, input, 8 bits each: next byte to send for each requester.
REQ-009 SHALL have port TX_POP, output, 2 bits: one-cycle pulse when the granted requester's TX byte is consumed.
REQ-010 SHALL have port RX_DATA, output, 8 bits: received byte.
REQ-011 SHALL have port RX_VLD, output, 2 bits: one-cycle pulse qualifying RX_DATA to the granted requester.
REQ-012 SHALL have port GNT, output, 2 bits: one-hot grant, held for the whole transaction.
REQ-013 SHALL have port DONE, output, 2 bits: one-cycle end-of-transaction pulse.
REQ-014 SHALL have port ERR, output, 2 bits: asserted together with DONE when the transaction aborted on timeout.
REQ-015 SHALL have port CS_N, output, 1 bit: SPI chip select, active low.
REQ-016 SHALL have port W_STB, output, 1 bit: byte-engine write strobe.
REQ-017 SHALL have port W_DATA, output, 8 bits: byte-engine write data.
REQ-018 SHALL have port W_ACK, input, 1 bit: byte-engine write-complete indication.
REQ-019 SHALL have ports R_STB, input, 1 bit, and R_DATA, input, 8 bits: byte-engine receive strobe and data.

Function
REQ-020 SHALL implement the state machine IDLE, SETUP, SEND, WAIT, NEXT, HOLD, FIN, with all outputs registered.
REQ-021 In IDLE, SHALL treat requester i as eligible only when REQ[i]=1 and LENi!=0.
REQ-022 In IDLE, SHALL choose among eligible requesters by round-robin: the one not served last wins a tie.
REQ-023 In IDLE, upon choosing a requester, SHALL latch its LEN and assert GNT one-hot and CS_N=0 on the next edge, then enter SETUP.
REQ-024 SETUP SHALL last exactly CS_SETUP cycles and then enter SEND.
REQ-025 SEND SHALL last 1 cycle, during which W_STB=1, W_DATA=TX_DATA of the granted requester, and TX_POP[g]=1; it then enters WAIT and clears the timer.
REQ-026 In WAIT, SHALL record W_ACK and R_STB as sticky per-byte flags.
REQ-027 On the first R_STB of a byte, SHALL register RX_DATA=R_DATA and pulse RX_VLD[g] on the next cycle; any further R_STB within the same byte SHALL be ignored.
REQ-028 WAIT SHALL exit to NEXT when both the W_ACK and R_STB flags are set, including when both inputs arrive in the same cycle.
REQ-029 If the timer reaches TIMEOUT before WAIT exits, SHALL set the error flag and go to HOLD, abandoning the remaining bytes.
REQ-030 NEXT SHALL decrement the remaining count and go to SEND if the result is nonzero, otherwise to HOLD.
REQ-031 HOLD SHALL keep CS_N=0 for CS_HOLD cycles and then enter FIN.
REQ-032 FIN SHALL set CS_N=1, pulse DONE[g] (and ERR[g] if the error flag is set), clear GNT, update last-served, and return to IDLE.
REQ-033 SHALL guarantee at least one IDLE cycle with CS_N=1 between transactions, so that a continuously requesting requester still yields to the other on the tie rule.
REQ-034 SHALL ignore REQ deassertion and LEN changes after the grant; the transaction completes with the latched LEN.
REQ-035 SHALL ignore W_ACK and R_STB outside WAIT.
REQ-036 SHALL never assert GNT, TX_POP, RX_VLD, DONE or ERR on more than one bit at a time.
REQ-037 SHALL size the timer at 6 bits, saturating.

Reset
REQ-038 While RST=1, outputs SHALL take these values immediately, independent of IN_SCLK: CS_N=1, W_STB=0, W_DATA=0, GNT=0, TX_POP=0, RX_VLD=0, RX_DATA=0, DONE=0, ERR=0.
REQ-039 While RST=1, the state SHALL be IDLE, the remaining count and timer SHALL be 0, and last-served SHALL be 1 (requester 0 wins the first tie).
REQ-040 Reset mid-transaction SHALL abort without emitting DONE or ERR and raise CS_N at once; the first grant after release follows REQ-021..023.

Verification
REQ-041 With REQ=01, LEN0=3, and an engine model that acks at 9 cycles with R_STB at 10, the bench SHALL see 3 TX_POP[0] pulses, 3 RX_VLD[0] pulses, CS_N low for 2+3*(1+10+1)+2 cycles, and then DONE[0]=1 with ERR=0.
REQ-042 With REQ=11 held and LEN0=LEN1=1 after reset, the bench SHALL see the grant order 0,1,0,1, each DONE a single pulse, and CS_N high for at least 1 cycle between transactions.
REQ-043 With an engine that never asserts R_STB and LEN1=4, the bench SHALL see the timeout after 32 cycles in WAIT, only 1 TX_POP[1], and DONE[1]=ERR[1]=1 after the hold.
REQ-044 With W_ACK and R_STB=1 in the same cycle and a duplicate R_STB on the next cycle, the bench SHALL see exactly one RX_VLD pulse whose data equals the first R_DATA.
REQ-045 With RST asserted during WAIT of byte 2, the bench SHALL see CS_N=1 and GNT=0 asynchronously with no DONE, and after release REQ=01 SHALL be regranted to requester 0.
REQ-046 With REQ=10 and LEN1=0 held for 20 cycles, the bench SHALL see no grant and CS_N=1 throughout.

Source files
------------

// File: rtl/spi_seq.sv
// spi_seq: SPI transaction sequencer arbitrating two requesters onto a byte engine.
//
// Ports:
//   in_sclk            single clock, rising edge
//   rst                asynchronous active-high reset
//   req[1:0]           per-requester transaction request (level)
//   len0, len1         byte count per requester, 0 = nothing to do
//   tx_data0, tx_data1 next byte to send per requester
//   tx_pop[1:0]        pulse when the granted requester's byte is consumed
//   rx_data, rx_vld    received byte and its per-requester qualifier pulse
//   gnt[1:0]           one-hot grant, held for the whole transaction
//   done[1:0], err[1:0] end-of-transaction pulse, err on timeout abort
//   cs_n               SPI chip select, active low
//   w_stb, w_data      byte-engine write strobe and data
//   w_ack              byte-engine write complete
//   r_stb, r_data      byte-engine receive strobe and data
module spi_seq #(
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic       in_sclk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] tx_pop,
  output logic [7:0] rx_data,
  output logic [1:0] rx_vld,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic       cs_n,
  output logic       w_stb,
  output logic [7:0] w_data,
  input  logic       w_ack,
  input  logic       r_stb,
  input  logic [7:0] r_data
);

  typedef enum logic [2:0] {
    StIdle, StSetup, StSend, StWait, StNext, StHold, StFin
  } state_e;

  localparam logic [3:0] SetupLast  = 4'(CS_SETUP - 1);
  localparam logic [3:0] HoldLast   = 4'(CS_HOLD - 1);
  localparam logic [5:0] TimeoutVal = 6'(TIMEOUT);

  state_e     state_q;
  logic       gidx_q;   // index of the granted requester
  logic       last_q;   // last requester served, loses the next tie
  logic       ack_q;    // sticky w_ack seen for the current byte
  logic       rx_q;     // sticky r_stb seen for the current byte
  logic       err_q;    // transaction aborted on timeout
  logic [3:0] rem_q;
  logic [3:0] cnt_q;
  logic [5:0] timer_q;

  logic [1:0] elig;
  logic [1:0] gsel;
  logic       pick;
  logic       ack_seen;
  logic       rx_seen;
  logic [5:0] timer_nxt;
  logic [7:0] tx_sel;

  always_comb begin
    elig      = {req[1] && (len1 != 4'd0), req[0] && (len0 != 4'd0)};
    pick      = (elig == 2'b11) ? ~last_q : elig[1];
    gsel      = gidx_q ? 2'b10 : 2'b01;
    tx_sel    = gidx_q ? tx_data1 : tx_data0;
    // Inputs arriving this cycle count, so ack and rx together exit at once.
    ack_seen  = ack_q | w_ack;
    rx_seen   = rx_q | r_stb;
    timer_nxt = (timer_q == 6'h3f) ? timer_q : timer_q + 6'd1;
  end

  always_ff @(posedge in_sclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gidx_q  <= 1'b0;
      last_q  <= 1'b1;
      ack_q   <= 1'b0;
      rx_q    <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= 4'd0;
      cnt_q   <= 4'd0;
      timer_q <= 6'd0;
      tx_pop  <= 2'b00;
      rx_data <= 8'd0;
      rx_vld  <= 2'b00;
      gnt     <= 2'b00;
      done    <= 2'b00;
      err     <= 2'b00;
      cs_n    <= 1'b1;
      w_stb   <= 1'b0;
      w_data  <= 8'd0;
    end else begin
      // Pulsed outputs default low every cycle.
      tx_pop <= 2'b00;
      rx_vld <= 2'b00;
      done   <= 2'b00;
      err    <= 2'b00;
      w_stb  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (elig != 2'b00) begin
            gidx_q  <= pick;
            gnt     <= pick ? 2'b10 : 2'b01;
            rem_q   <= pick ? len1 : len0;
            cs_n    <= 1'b0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            w_stb   <= 1'b1;
            w_data  <= tx_sel;
            tx_pop  <= gsel;
            state_q <= StSend;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StSend: begin
          timer_q <= 6'd0;
          ack_q   <= 1'b0;
          rx_q    <= 1'b0;
          state_q <= StWait;
        end
        StWait: begin
          if (w_ack) begin
            ack_q <= 1'b1;
          end
          // Only the first receive strobe of a byte is delivered.
          if (r_stb && !rx_q) begin
            rx_q    <= 1'b1;
            rx_data <= r_data;
            rx_vld  <= gsel;
          end
          if (ack_seen && rx_seen) begin
            state_q <= StNext;
          end else if (timer_nxt == TimeoutVal) begin
            err_q   <= 1'b1;
            cnt_q   <= 4'd0;
            state_q <= StHold;
          end else begin
            timer_q <= timer_nxt;
          end
        end
        StNext: begin
          rem_q <= rem_q - 4'd1;
          if (rem_q != 4'd1) begin
            w_stb   <= 1'b1;
            w_data  <= tx_sel;
            tx_pop  <= gsel;
            state_q <= StSend;
          end else begin
            cnt_q   <= 4'd0;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            cs_n    <= 1'b1;
            done    <= gsel;
            err     <= err_q ? gsel : 2'b00;
            state_q <= StFin;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StFin: begin
          gnt     <= 2'b00;
          last_q  <= gidx_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_seq.sv
// tb_spi_seq: directed self-checking bench for spi_seq with a byte-engine model,
// an event monitor and rx/tx scoreboards.
module tb_spi_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] len0 = 4'd0;
  logic [3:0] len1 = 4'd0;
  logic [7:0] tx_data0 = 8'h10;
  logic [7:0] tx_data1 = 8'h80;
  logic [1:0] tx_pop, rx_vld, gnt, done, err;
  logic [7:0] rx_data, w_data;
  logic       cs_n, w_stb;
  logic       w_ack = 1'b0;
  logic       r_stb = 1'b0;
  logic [7:0] r_data = 8'd0;

  always #5 clk = ~clk;

  spi_seq #(.CS_SETUP(2), .CS_HOLD(2), .TIMEOUT(32)) dut (
    .in_sclk (clk),
    .rst     (rst),
    .req     (req),
    .len0    (len0),
    .len1    (len1),
    .tx_data0(tx_data0),
    .tx_data1(tx_data1),
    .tx_pop  (tx_pop),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .cs_n    (cs_n),
    .w_stb   (w_stb),
    .w_data  (w_data),
    .w_ack   (w_ack),
    .r_stb   (r_stb),
    .r_data  (r_data)
  );

  int checks = 0;
  int failures = 0;

  // Byte-engine model: cycle 0 is the w_stb cycle.
  int         ack_dly = 9;
  int         rstb_dly = 10;
  bit         rstb_en = 1'b1;
  bit         dup_rstb = 1'b0;
  int         eng_cnt = 0;
  bit         eng_on = 1'b0;
  logic [7:0] eng_byte = 8'd0;
  logic [7:0] exp_rx[$];

  always @(negedge clk) begin
    if (rst) eng_on = 1'b0;
    else if (w_stb) begin
      eng_on = 1'b1;
      eng_cnt = 0;
      eng_byte = w_data;
    end else if (eng_on) eng_cnt++;
    w_ack = eng_on && (eng_cnt == ack_dly);
    r_stb = eng_on && rstb_en &&
            ((eng_cnt == rstb_dly) || (dup_rstb && (eng_cnt == rstb_dly + 1)));
    r_data = (eng_cnt == rstb_dly) ? (eng_byte ^ 8'h5A) : 8'hEE;
    if (eng_on && rstb_en && (eng_cnt == rstb_dly)) exp_rx.push_back(eng_byte ^ 8'h5A);
  end

  // Monitor: logs DUT events; also feeds a fresh tx byte after every pop.
  int         cyc = 0;
  logic [8:0] obs_pop[$];
  logic [8:0] obs_rx[$];
  logic [3:0] obs_done[$];
  int         done_cyc[$];
  int         stb_cyc[$];
  int         cs_low_q[$];
  int         cs_high_q[$];
  int         low_run = 0;
  int         high_run = 0;
  logic [1:0] gnt_seq[$];
  logic [1:0] gnt_prev = 2'b00;
  bit         onehot_bad = 1'b0;
  bit         pop_bad = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (w_stb != (tx_pop != 2'b00)) pop_bad = 1'b1;
    if (tx_pop != 2'b00) begin
      obs_pop.push_back({tx_pop[1], w_data});
      stb_cyc.push_back(cyc);
      if (tx_pop != gnt) pop_bad = 1'b1;
      if (tx_pop[0]) tx_data0 = tx_data0 + 8'h01;
      if (tx_pop[1]) tx_data1 = tx_data1 + 8'h01;
    end
    if (rx_vld != 2'b00) begin
      obs_rx.push_back({rx_vld[1], rx_data});
      if ((rx_vld & ~gnt) != 2'b00) onehot_bad = 1'b1;
    end
    if ((done | err) != 2'b00) begin
      obs_done.push_back({done, err});
      done_cyc.push_back(cyc);
    end
    if (!$onehot0(gnt) || !$onehot0(tx_pop) || !$onehot0(rx_vld) ||
        !$onehot0(done) || !$onehot0(err)) onehot_bad = 1'b1;
    if (gnt != gnt_prev && gnt != 2'b00) gnt_seq.push_back(gnt);
    gnt_prev = gnt;
    if (cs_n) begin
      if (low_run != 0) cs_low_q.push_back(low_run);
      low_run = 0;
      high_run++;
    end else begin
      if (high_run != 0) cs_high_q.push_back(high_run);
      high_run = 0;
      low_run++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (obs_done.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, obs_done.size(), n);
  endtask

  function automatic int last_low();
    return (cs_low_q.size() > 0) ? cs_low_q[cs_low_q.size() - 1] : -1;
  endfunction

  function automatic logic [3:0] last_done();
    return (obs_done.size() > 0) ? obs_done[obs_done.size() - 1] : 4'hF;
  endfunction

  initial begin
    int d0, g0, l0, h0, p0, r0, s0, n0, k, min_high;
    logic [7:0]  gseq;
    logic [15:0] dseq;
    logic [1:0]  acc_gnt;
    logic        acc_cs;
    logic [7:0]  e0, e1;

    // Reset outputs appear before any clock edge.
    #1 rst = 1'b1;
    #1 check("reset_outputs", {cs_n, w_stb, w_data, gnt, tx_pop, rx_vld, rx_data, done, err},
             {1'b1, 27'd0});
    repeat (3) step();
    rst = 1'b0;
    step();

    // Requester 1 asks with length 0: nothing happens.
    req = 2'b10; len1 = 4'd0; len0 = 4'd5;
    acc_gnt = 2'b00; acc_cs = 1'b1;
    repeat (20) begin
      step();
      acc_gnt |= gnt;
      acc_cs &= cs_n;
    end
    check("len0_no_grant", {acc_gnt, acc_cs}, 3'b001);
    req = 2'b00;
    step();

    // Both requesting, one byte each: strict alternation starting at 0.
    d0 = obs_done.size(); g0 = gnt_seq.size(); l0 = cs_low_q.size(); h0 = cs_high_q.size();
    len0 = 4'd1; len1 = 4'd1; req = 2'b11;
    wait_done(d0 + 4, 400, "rr_done_wait");
    req = 2'b00;
    repeat (3) step();
    check("rr_done_count", obs_done.size(), d0 + 4);
    check("rr_grant_count", gnt_seq.size() - g0, 4);
    gseq = 8'h00;
    for (int i = 0; i < 4; i++) gseq = {gseq[5:0], (g0 + i < gnt_seq.size()) ? gnt_seq[g0 + i] : 2'b00};
    check("rr_grant_order", gseq, 8'b01_10_01_10);
    dseq = 16'h0000;
    for (int i = 0; i < 4; i++) dseq = {dseq[11:0], (d0 + i < obs_done.size()) ? obs_done[d0 + i] : 4'hF};
    check("rr_done_seq", dseq, 16'h4848);
    check("rr_cs_low_runs", cs_low_q.size() - l0, 4);
    min_high = 1000;
    for (int i = h0 + 1; i < cs_high_q.size(); i++) if (cs_high_q[i] < min_high) min_high = cs_high_q[i];
    check("rr_cs_gap", (min_high >= 1) && (cs_high_q.size() - h0 >= 4), 1'b1);

    // Requester 0, three bytes, ack at 9 and rx at 10.
    d0 = obs_done.size(); p0 = obs_pop.size(); r0 = obs_rx.size();
    len0 = 4'd3; req = 2'b01;
    wait_done(d0 + 1, 200, "three_done_wait");
    req = 2'b00;
    step();
    n0 = 0;
    for (int i = p0; i < obs_pop.size(); i++) if (!obs_pop[i][8]) n0++;
    check("three_pops", {obs_pop.size() - p0, n0}, {32'd3, 32'd3});
    check("three_rx", obs_rx.size() - r0, 3);
    check("three_cs_low", last_low(), 40);
    check("three_done", last_done(), 4'b0100);

    // Requester 1, four bytes, engine never returns data: timeout.
    d0 = obs_done.size(); p0 = obs_pop.size(); s0 = stb_cyc.size();
    rstb_en = 1'b0; len1 = 4'd4; req = 2'b10;
    wait_done(d0 + 1, 200, "tmo_done_wait");
    req = 2'b00;
    step();
    check("tmo_pops", {obs_pop.size() - p0, (obs_pop.size() > p0) ? obs_pop[p0][8] : 1'b0},
          {32'd1, 1'b1});
    check("tmo_done_err", last_done(), 4'b1010);
    check("tmo_latency", (stb_cyc.size() > s0 && done_cyc.size() > 0) ?
          done_cyc[done_cyc.size() - 1] - stb_cyc[s0] : -1, 35);
    check("tmo_cs_low", last_low(), 37);
    rstb_en = 1'b1;

    // Ack and rx together, duplicate rx on the next cycle.
    d0 = obs_done.size(); r0 = obs_rx.size();
    ack_dly = 4; rstb_dly = 4; dup_rstb = 1'b1; len0 = 4'd1; req = 2'b01;
    wait_done(d0 + 1, 100, "same_done_wait");
    req = 2'b00;
    step();
    check("same_rx_once", obs_rx.size() - r0, 1);
    check("same_cs_low", last_low(), 10);
    check("same_done", last_done(), 4'b0100);

    // Duplicate rx strobe while still waiting for the ack.
    d0 = obs_done.size(); r0 = obs_rx.size();
    ack_dly = 6; rstb_dly = 3; req = 2'b01;
    wait_done(d0 + 1, 100, "dup_done_wait");
    req = 2'b00;
    step();
    check("dup_rx_once", obs_rx.size() - r0, 1);
    check("dup_cs_low", last_low(), 12);
    ack_dly = 9; rstb_dly = 10; dup_rstb = 1'b0;

    // Reset during the wait of byte 2.
    d0 = obs_done.size(); s0 = stb_cyc.size();
    len0 = 4'd3; req = 2'b01;
    k = 0;
    while (stb_cyc.size() < s0 + 2 && k < 100) begin
      step();
      k++;
    end
    check("rst_second_byte", stb_cyc.size(), s0 + 2);
    repeat (5) step();
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", {cs_n, gnt, done, err}, 7'b1_00_00_00);
    repeat (3) step();
    check("rst_no_done", obs_done.size(), d0);
    rst = 1'b0;
    k = 0;
    while (gnt == 2'b00 && k < 10) begin
      step();
      k++;
    end
    check("rst_regrant", gnt, 2'b01);
    wait_done(d0 + 1, 200, "rst_done_wait");
    req = 2'b00;
    step();
    check("rst_done", last_done(), 4'b0100);

    // Scoreboards and sticky protocol flags.
    check("onehot_flags", {onehot_bad, pop_bad}, 2'b00);
    check("rx_count", obs_rx.size(), exp_rx.size());
    for (int i = 0; i < obs_rx.size() && i < exp_rx.size(); i++) begin
      check($sformatf("rx_byte%0d", i), obs_rx[i][7:0], exp_rx[i]);
    end
    e0 = 8'h10; e1 = 8'h80;
    for (int i = 0; i < obs_pop.size(); i++) begin
      if (obs_pop[i][8]) begin
        check($sformatf("tx_byte%0d", i), obs_pop[i][7:0], e1);
        e1 = e1 + 8'h01;
      end else begin
        check($sformatf("tx_byte%0d", i), obs_pop[i][7:0], e0);
        e0 = e0 + 8'h01;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
